multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multicycle MIPS-style datapath
//
// Ports:
//   clk       - single clock, rising edge
//   reset     - synchronous, active-high; forces FETCH0
//   Op        - opcode field from the instruction register
//   MemWrite  - memory write enable
//   IorD      - memory address select (0 = PC, 1 = ALUOut)
//   IRWrite   - instruction register load
//   PCWrite   - unconditional PC load
//   Branch    - BEQ PC-load qualifier
//   RegWrite  - register file write strobe
//   MemtoReg  - write-back data select (1 = memory data)
//   RegDst    - destination register select (1 = rd)
//   ALUSrcA   - ALU A select (0 = PC, 1 = register A)
//   ALUSrcB   - ALU B select (00 = B, 01 = 4, 10 = imm, 11 = imm<<2)
//   ALUOp     - ALU decoder class
//   PCSrc     - next-PC select
//   state_o   - current state encoding for debug
module multicycle_control #(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Op,
    output logic                   MemWrite,
    output logic                   IorD,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   Branch,
    output logic                   RegWrite,
    output logic                   MemtoReg,
    output logic                   RegDst,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [1:0]             ALUOp,
    output logic [1:0]             PCSrc,
    output logic [STATE_WIDTH-1:0] state_o
);

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [STATE_WIDTH-1:0] {
        FETCH0   = STATE_WIDTH'(0),
        FETCH1   = STATE_WIDTH'(1),
        DECODE   = STATE_WIDTH'(2),
        MEMADR   = STATE_WIDTH'(3),
        MEMREAD  = STATE_WIDTH'(4),
        MEMWAIT  = STATE_WIDTH'(5),
        MEMWB    = STATE_WIDTH'(6),
        MEMWRITE = STATE_WIDTH'(7),
        EXECUTE  = STATE_WIDTH'(8),
        ALUWB    = STATE_WIDTH'(9),
        BRANCH   = STATE_WIDTH'(10),
        ADDIEX   = STATE_WIDTH'(11),
        ADDIWB   = STATE_WIDTH'(12),
        JUMP     = STATE_WIDTH'(13)
    } state_t;

    typedef struct packed {
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;

    // Opcode is only consulted in DECODE and MEMADR; every other state
    // advances unconditionally. Unused encodings fall back to FETCH0.
    function automatic state_t next_of(input state_t s, input logic [5:0] op);
        state_t n;
        n = FETCH0;
        case (s)
            FETCH0:  n = FETCH1;
            FETCH1:  n = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_RTYPE:     n = EXECUTE;
                    OP_BEQ:       n = BRANCH;
                    OP_ADDI:      n = ADDIEX;
                    OP_J:         n = JUMP;
                    default:      n = FETCH0;
                endcase
            end
            MEMADR:  n = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: n = MEMWAIT;
            MEMWAIT: n = MEMWB;
            EXECUTE: n = ALUWB;
            ADDIEX:  n = ADDIWB;
            default: n = FETCH0;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH0: c.alu_src_b = 2'b01;
            FETCH1: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMREAD, MEMWAIT: c.iord = 1'b1;
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b01;
                c.branch    = 1'b1;
                c.pc_src    = 2'b01;
            end
            ADDIWB: c.reg_write = 1'b1;
            JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Outputs are registered from the decode of the state being entered,
    // so they always reflect the state register without a combinational
    // path from Op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH0;
            ctrl  <= decode(FETCH0);
        end else begin
            state <= next_of(state, Op);
            ctrl  <= decode(next_of(state, Op));
        end
    end

    assign MemWrite = ctrl.mem_write;
    assign IorD     = ctrl.iord;
    assign IRWrite  = ctrl.ir_write;
    assign PCWrite  = ctrl.pc_write;
    assign Branch   = ctrl.branch;
    assign RegWrite = ctrl.reg_write;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegDst   = ctrl.reg_dst;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign ALUOp    = ctrl.alu_op;
    assign PCSrc    = ctrl.pc_src;
    assign state_o  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite;
    logic       MemtoReg, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         st;
        logic [5:0] op;
    } exp_t;

    exp_t q[$];

    multicycle_control #(.STATE_WIDTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .Op       (Op),
        .MemWrite (MemWrite),
        .IorD     (IorD),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .Branch   (Branch),
        .RegWrite (RegWrite),
        .MemtoReg (MemtoReg),
        .RegDst   (RegDst),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // {MemWrite,IorD,IRWrite,PCWrite,Branch,RegWrite,MemtoReg,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
    logic [14:0] ctrl_vec;
    assign ctrl_vec = {MemWrite, IorD, IRWrite, PCWrite, Branch, RegWrite,
                       MemtoReg, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSrc};

    function automatic logic [14:0] exp_ctrl(input int s);
        case (s)
            0:       return 15'b0_0_0_0_0_0_0_0_0_01_00_00;
            1:       return 15'b0_0_1_1_0_0_0_0_0_01_00_00;
            2:       return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
            3, 11:   return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
            4, 5:    return 15'b0_1_0_0_0_0_0_0_0_00_00_00;
            6:       return 15'b0_0_0_0_0_1_1_0_0_00_00_00;
            7:       return 15'b1_1_0_0_0_0_0_0_0_00_00_00;
            8:       return 15'b0_0_0_0_0_0_0_0_1_00_10_00;
            9:       return 15'b0_0_0_0_0_1_0_1_0_00_00_00;
            10:      return 15'b0_0_0_0_1_0_0_0_1_00_01_01;
            12:      return 15'b0_0_0_0_0_1_0_0_0_00_00_00;
            13:      return 15'b0_0_0_1_0_0_0_0_0_00_00_10;
            default: return 15'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_instr(input logic [5:0] op, input int len, input int seq[8]);
        for (int i = 0; i < len; i++) begin
            exp_t e;
            e.st = seq[i];
            e.op = op;
            q.push_back(e);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Pops one expected state per cycle; Op carries the instruction only in
    // DECODE/MEMADR and junk elsewhere so that unsampled changes are exercised.
    task automatic drain;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check($sformatf("state(exp %0d)", e.st), 32'(state_o), 32'(e.st));
            check($sformatf("ctrl(st %0d)", e.st), 32'(ctrl_vec), 32'(exp_ctrl(e.st)));
            check("pcwrite_branch_excl", 32'(PCWrite & Branch), 32'd0);
            check("memwrite_irwrite_excl", 32'(MemWrite & IRWrite), 32'd0);
            if (e.st == 2 || e.st == 3) Op = e.op;
            else                        Op = 6'($urandom_range(0, 63));
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        Op    = 6'b101011;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_state", 32'(state_o), 32'd0);
            check("reset_strobes", 32'({MemWrite, IRWrite, PCWrite, Branch, RegWrite}), 32'd0);
            next_cycle();
        end
        reset = 1'b0;

        push_instr(6'b100011, 7, '{0, 1, 2, 3, 4, 5, 6, 0});
        push_instr(6'b101011, 5, '{0, 1, 2, 3, 7, 0, 0, 0});
        push_instr(6'b000100, 4, '{0, 1, 2, 10, 0, 0, 0, 0});
        push_instr(6'b000010, 4, '{0, 1, 2, 13, 0, 0, 0, 0});
        push_instr(6'b111111, 3, '{0, 1, 2, 0, 0, 0, 0, 0});
        push_instr(6'b000000, 5, '{0, 1, 2, 8, 9, 0, 0, 0});
        push_instr(6'b001000, 5, '{0, 1, 2, 11, 12, 0, 0, 0});
        push_instr(6'b110000, 3, '{0, 1, 2, 0, 0, 0, 0, 0});
        push_instr(6'b101011, 4, '{0, 1, 2, 3, 0, 0, 0, 0});
        drain();

        // Interrupt a store in MEMWRITE with reset.
        check("pre_reset_state", 32'(state_o), 32'd7);
        check("pre_reset_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        Op    = 6'b100011;
        next_cycle();
        check("midreset_state", 32'(state_o), 32'd0);
        check("midreset_memwrite", 32'(MemWrite), 32'd0);
        check("midreset_strobes", 32'({MemWrite, IRWrite, PCWrite, Branch, RegWrite}), 32'd0);
        next_cycle();
        check("hold_reset_state", 32'(state_o), 32'd0);
        check("hold_reset_memwrite", 32'(MemWrite), 32'd0);
        reset = 1'b0;

        push_instr(6'b100011, 7, '{0, 1, 2, 3, 4, 5, 6, 0});
        push_instr(6'b000000, 1, '{0, 0, 0, 0, 0, 0, 0, 0});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
